keyed_ring_perm_stage: RTL and testbench

- Parametrised, handshaked successor to the fixed 4×4 byte-permutation pipeline stage of the crypto accelerator.
- Accepts an N×N byte state plus a per-block key (ring select, direction) and rotates one concentric ring of the matrix by 90°. All other bytes pass through unchanged.
- Registers the result behind a valid/ready interface with a one-entry skid buffer, so the stage drops into the round pipeline without stalling upstream on a single-cycle back-pressure.

---
 rtl/krps_pkg.sv | 23 ++
 rtl/krps_ring_rotate.sv | 31 +++
 rtl/keyed_ring_perm_stage.sv | 100 ++++++++++
 tb/tb_keyed_ring_perm_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/krps_pkg.sv
// Shared helpers for the keyed ring permutation stage: ring geometry and direction encoding.
package krps_pkg;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    // Width of the ring select: enough to name every concentric ring, never less than 1 bit.
    function automatic int ring_w(input int n);
        int rings;
        rings = (n + 1) / 2;
        return (rings <= 1) ? 1 : $clog2(rings);
    endfunction

    function automatic int ring_of(input int i, input int j, input int n);
        int m;
        m = i;
        if (j < m)         m = j;
        if (n - 1 - i < m) m = n - 1 - i;
        if (n - 1 - j < m) m = n - 1 - j;
        return m;
    endfunction

endpackage

// File: rtl/krps_ring_rotate.sv
// Combinational 90-degree rotation of one concentric ring of an NxN byte matrix.
// Zero latency; no flow control. Ring selects beyond the last ring leave the block untouched.
module krps_ring_rotate import krps_pkg::*; #(
    parameter int N      = 4,
    parameter int BYTE_W = 8
) (
    input  logic [N*N*BYTE_W-1:0] data_i,
    input  logic [ring_w(N)-1:0]  ring_i,
    input  logic                  dir_i,
    output logic [N*N*BYTE_W-1:0] data_o
);

    localparam int RW = ring_w(N);

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            localparam int DST     = i * N + j;
            localparam int SRC_CW  = (N - 1 - j) * N + i;
            localparam int SRC_CCW = j * N + (N - 1 - i);
            localparam logic [RW-1:0] RING = RW'(ring_of(i, j, N));

            // Source positions are fixed per element; only the ring match and direction are dynamic.
            logic [BYTE_W-1:0] rot;
            assign rot = (dir_i == DIR_CW) ? data_i[SRC_CW*BYTE_W +: BYTE_W]
                                           : data_i[SRC_CCW*BYTE_W +: BYTE_W];
            assign data_o[DST*BYTE_W +: BYTE_W] = (ring_i == RING) ? rot
                                                                  : data_i[DST*BYTE_W +: BYTE_W];
        end
    end

endmodule

// File: rtl/keyed_ring_perm_stage.sv
// Keyed ring-rotation pipeline stage: 1-cycle latency, output register plus one-entry skid;
// in_ready depends only on skid occupancy. Defining KRPS_INV_EN adds in_inv to flip direction.
module keyed_ring_perm_stage import krps_pkg::*; #(
    parameter int N      = 4,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*N*BYTE_W-1:0] in_data,
    input  logic [ring_w(N)-1:0]  in_ring,
    input  logic                  in_dir,
`ifdef KRPS_INV_EN
    input  logic                  in_inv,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*N*BYTE_W-1:0] out_data,
    output logic [CNT_W-1:0]      blk_cnt
);

    localparam int DW = N * N * BYTE_W;

    logic          dir_eff;
    logic [DW-1:0] perm;
    logic [DW-1:0] or_q, or_d;
    logic [DW-1:0] sk_q, sk_d;
    logic          or_v_q, or_v_d;
    logic          sk_v_q, sk_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          drain;

`ifdef KRPS_INV_EN
    assign dir_eff = in_dir ^ in_inv;
`else
    assign dir_eff = in_dir;
`endif

    krps_ring_rotate #(
        .N      (N),
        .BYTE_W (BYTE_W)
    ) u_rot (
        .data_i (in_data),
        .ring_i (in_ring),
        .dir_i  (dir_eff),
        .data_o (perm)
    );

    assign in_ready = !sk_v_q;
    assign accept   = in_valid && !sk_v_q;
    assign drain    = or_v_q && out_ready;

    // Skid holds already-permuted data, so the key never outlives its accept cycle.
    always_comb begin
        or_d   = or_q;
        sk_d   = sk_q;
        or_v_d = or_v_q;
        sk_v_d = sk_v_q;
        cnt_d  = cnt_q;
        if (drain) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (drain && sk_v_q) begin
            or_d   = sk_q;
            sk_v_d = 1'b0;
        end else if (accept && (!or_v_q || drain)) begin
            or_d   = perm;
            or_v_d = 1'b1;
        end else if (accept) begin
            sk_d   = perm;
            sk_v_d = 1'b1;
        end else if (drain) begin
            or_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            or_q   <= '0;
            sk_q   <= '0;
            or_v_q <= 1'b0;
            sk_v_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            or_q   <= or_d;
            sk_q   <= sk_d;
            or_v_q <= or_v_d;
            sk_v_q <= sk_v_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = or_v_q;
    assign out_data  = or_q;
    assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_keyed_ring_perm_stage.sv
// Bench for keyed_ring_perm_stage (N=4, CNT_W=4): occupancy/scoreboard model plus directed vectors.
module tb_keyed_ring_perm_stage;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int DW = N * N * BW;
    localparam int RW = 1;
    localparam int CW = 4;
`ifdef KRPS_INV_EN
    localparam bit HAS_INV = 1'b1;
`else
    localparam bit HAS_INV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [RW-1:0] in_ring;
    logic          in_dir;
    logic          in_inv;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] blk_cnt;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] q[$];
    logic [CW-1:0] exp_cnt;

    always #5 clk = ~clk;

    keyed_ring_perm_stage #(.N(N), .BYTE_W(BW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ring   (in_ring),
        .in_dir    (in_dir),
`ifdef KRPS_INV_EN
        .in_inv    (in_inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .blk_cnt   (blk_cnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rotation straight from the matrix definition, on a 2-D array.
    function automatic logic [DW-1:0] ref_perm(input logic [DW-1:0] d, input int rg, input logic dir);
        logic [7:0] a[N][N];
        logic [DW-1:0] res;
        int ring;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                a[r][c] = d[(r*N+c)*BW +: BW];
        res = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ring = i;
                if (j < ring) ring = j;
                if (N-1-i < ring) ring = N-1-i;
                if (N-1-j < ring) ring = N-1-j;
                if (ring == rg)
                    res[(i*N+j)*BW +: BW] = dir ? a[j][N-1-i] : a[N-1-j][i];
                else
                    res[(i*N+j)*BW +: BW] = a[i][j];
            end
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: check outputs against the occupancy model, drive inputs, advance, update model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [RW-1:0] rg,
                        input logic dr, input logic iv, input logic rdy, output logic acc);
        logic drn;
        logic de;
        chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
        chk("in_ready", DW'(in_ready), DW'(q.size() < 2));
        chk("blk_cnt", DW'(blk_cnt), DW'(exp_cnt));
        if (q.size() > 0) chk("out_data", out_data, q[0]);
        in_valid  = v;
        in_data   = d;
        in_ring   = rg;
        in_dir    = dr;
        in_inv    = iv;
        out_ready = rdy;
        acc = v && (q.size() < 2);
        drn = rdy && (q.size() > 0);
        de  = dr ^ (HAS_INV ? iv : 1'b0);
        @(posedge clk);
        #1;
        if (drn) begin
            void'(q.pop_front());
            exp_cnt = exp_cnt + 1'b1;
        end
        if (acc) q.push_back(ref_perm(d, int'(rg), de));
    endtask

    task automatic pulse_reset(input string tag);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk({tag, "_out_valid"}, DW'(out_valid), DW'(0));
        chk({tag, "_in_ready"}, DW'(in_ready), DW'(1));
        chk({tag, "_blk_cnt"}, DW'(blk_cnt), DW'(0));
        chk({tag, "_out_data"}, out_data, DW'(0));
        q.delete();
        exp_cnt = '0;
        #1;
        reset = 1'b0;
    endtask

    task automatic drain_all();
        logic a;
        for (int k = 0; k < 8 && q.size() > 0; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
    endtask

    initial begin
        logic          a;
        logic [DW-1:0] ramp, tp0, tp1, x, y;
        logic [7:0]    e0[16];
        int            sent;
        logic [RW-1:0] r;
        logic          d;

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_ring = '0;
        in_dir = 1'b0; in_inv = 1'b0; out_ready = 1'b0; exp_cnt = '0;
        #1;
        pulse_reset("por");

        // Directed vectors on the ramp state (element (r,c) = r*4+c).
        e0 = '{8'h0C, 8'h08, 8'h04, 8'h00, 8'h0D, 8'h05, 8'h06, 8'h01,
               8'h0E, 8'h09, 8'h0A, 8'h02, 8'h0F, 8'h0B, 8'h07, 8'h03};
        for (int k = 0; k < 16; k++) begin
            ramp[k*BW +: BW] = 8'(k);
            tp0[k*BW +: BW]  = e0[k];
        end
        tp1 = ramp;
        tp1[5*BW +: BW]  = 8'h06;
        tp1[6*BW +: BW]  = 8'h0A;
        tp1[9*BW +: BW]  = 8'h05;
        tp1[10*BW +: BW] = 8'h09;
        step(1'b1, ramp, 1'b0, 1'b0, 1'b0, 1'b1, a);
        chk("tp_ring0_cw", out_data, tp0);
        step(1'b1, ramp, 1'b1, 1'b1, 1'b0, 1'b1, a);
        chk("tp_ring1_ccw", out_data, tp1);
        drain_all();

        // Loopback: four clockwise outer-ring rotations return the original block.
        pulse_reset("rst_loop");
        x = rand_data();
        step(1'b1, x, 1'b0, 1'b0, 1'b0, 1'b1, a);
        for (int k = 0; k < 3; k++) step(1'b1, out_data, 1'b0, 1'b0, 1'b0, 1'b1, a);
        chk("loop_ret", out_data, x);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
        chk("loop_cnt", DW'(blk_cnt), DW'(4));

        // Stall: 8 streamed blocks with out_ready low on cycles 3 and 4.
        sent = 0;
        for (int c = 0; c < 30 && sent < 8; c++) begin
            step(1'b1, rand_data(), RW'($urandom), 1'($urandom), 1'b0,
                 (c == 3 || c == 4) ? 1'b0 : 1'b1, a);
            if (a) sent++;
        end
        chk("stall_sent", DW'(sent), DW'(8));
        drain_all();

        // Encrypt then decrypt with the same key restores the block.
        for (int k = 0; k < 4; k++) begin
            x = rand_data();
            r = RW'($urandom);
            d = 1'($urandom);
            step(1'b1, x, r, d, 1'b0, 1'b1, a);
            step(1'b1, out_data, r, HAS_INV ? d : ~d, HAS_INV, 1'b1, a);
            chk("enc_dec", out_data, x);
        end
        drain_all();
`ifdef KRPS_INV_EN
        y = rand_data();
        step(1'b1, y, 1'b0, 1'b0, 1'b1, 1'b1, a);
        chk("inv_eq_ccw", out_data, ref_perm(y, 0, 1'b1));
        drain_all();
`else
        y = '0;
`endif

        // Random traffic against the scoreboard.
        for (int c = 0; c < 300; c++)
            step(1'($urandom_range(0, 3) != 0), rand_data(), RW'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 3) != 0), a);
        drain_all();

        // Reset while both OR and SK are full, then a fresh block's latency.
        step(1'b1, rand_data(), 1'b0, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, rand_data(), 1'b1, 1'b1, 1'b0, 1'b0, a);
        chk("full_in_ready", DW'(in_ready), DW'(0));
        pulse_reset("rst_mid");
        step(1'b1, rand_data(), 1'b0, 1'b1, 1'b0, 1'b0, a);
        chk("post_rst_valid", DW'(out_valid), DW'(1));
        drain_all();

        // Counter wrap: 16 drains from reset return blk_cnt to 0.
        pulse_reset("rst_wrap");
        for (int k = 0; k < 16; k++) step(1'b1, rand_data(), '0, 1'b0, 1'b0, 1'b1, a);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
        chk("cnt_wrap", DW'(blk_cnt), DW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
